prbs_bist_ctrl: RTL and testbench
=================================

Name: prbs_bist_ctrl

Overview:
Built-in self-test sequencer for the PRBS-15 pattern-detect/generate datapath. On Start, it drives the 32-bit sync pattern byte-by-byte onto the datapath input n times, then waits for the datapath Flag. It then checks a programmed number of returned PRBS-15 bytes against an internal reference LFSR. It reports busy/done, pass/fail, bit-error count and the failure cause to the test/register layer.

Parameters:
BusWidth, 8, data byte width (fixed 8; pattern split into 4 bytes)
NumWidth, 4, width of repeat-count input n
Pattern, 32'hAABBCCDD, sync pattern; sent MSB byte first
Seed, 15'h7FFF, reference LFSR seed (must be nonzero)
Timeout, 32, max cycles in WAIT_FLAG before failing
LenWidth, 16, width of CheckLen and ErrCount

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
Start  in  1  one-cycle start request
n  in  NumWidth  pattern repeat count, sampled at Start
CheckLen  in  LenWidth  PRBS bytes to check, sampled at Start
ErrThresh  in  LenWidth  max bit errors for pass, sampled at Start
TxData  out  BusWidth  byte to datapath InData
TxValid  out  1  TxData valid
RxFlag  in  1  datapath Flag (pattern detected, PRBS running)
RxData  in  BusWidth  datapath OutData
RxValid  in  1  RxData valid this cycle
Busy  out  1  high in any state except IDLE
Done  out  1  one-cycle pulse on test completion
Pass  out  1  result of last test, held until next Start
TimeoutErr  out  1  last test failed on missing Flag
ErrCount  out  LenWidth  bit errors in last/current test, saturating

Behaviour:
- Reset (async, RST=1): state IDLE. TxData=0, TxValid=0, Busy=0, Done=0, Pass=0, TimeoutErr=0, ErrCount=0. Reference LFSR=Seed. All counters 0. Reset mid-test aborts immediately; no Done pulse.
- States: IDLE, SEND, WAIT_FLAG, CHECK, FINISH.
- IDLE: Start=1 latches n, CheckLen and ErrThresh. It clears ErrCount, Pass and TimeoutErr, loads LFSR=Seed, and moves to SEND. n=0 is treated as 1. Start is ignored outside IDLE.
- SEND: registered outputs. TxValid=1 for exactly 4*n' consecutive cycles, starting the cycle after Start. TxData cycles Pattern[31:24], [23:16], [15:8], [7:0] and repeats. After the last byte, TxValid=0 and TxData=0; go to WAIT_FLAG.
- WAIT_FLAG: the cycle counter increments each cycle. RxFlag=1 moves to CHECK next cycle and clears the counter. If the counter reaches Timeout with no RxFlag: TimeoutErr=1, Pass=0, go to FINISH.
- CHECK: on each cycle with RxValid=1, compare RxData with the reference byte. ErrCount += popcount(RxData XOR ref), saturating at all-ones. The LFSR advances 8 steps and the byte counter increments. Cycles with RxValid=0 do not advance or count.
  - After CheckLen accepted bytes, go to FINISH with Pass = (ErrCount <= ErrThresh), using the final count including the last byte.
  - CheckLen=0 goes straight to FINISH with Pass=1.
  - RxFlag falling in CHECK: stop, Pass=0, TimeoutErr=0, go to FINISH.
- FINISH: Done=1 for one cycle, then IDLE. Busy is low from the IDLE cycle onward. Pass, TimeoutErr and ErrCount hold.
- Reference LFSR is Fibonacci x^15+x^14+1. Per step: fb = s[14]^s[13]; s <= {s[13:0],fb}; output bit = fb. A byte is 8 consecutive output bits, first bit in the MSB. With Seed 7FFF the first bytes are 0x00, 0x02.
- Start coincident with RST: reset wins.

Test Plan:
- n=4, CheckLen=16, ErrThresh=0. Loopback model asserts RxFlag after the 16th byte and returns the reference stream. Required: TxData AA,BB,CC,DD x4 with TxValid high exactly 16 cycles; Done pulse; Pass=1, ErrCount=0.
- Same setup, model returns byte 1 as 0x03 instead of 0x02. Required: ErrCount=1, Pass=0; with ErrThresh=1, Pass=1.
- RxFlag never asserted. Required: Done exactly 32 cycles after WAIT_FLAG entry; TimeoutErr=1, Pass=0, ErrCount=0.
- n=0: required 4 Tx bytes only. Then CheckLen=4 with RxValid toggling 1/0. Required: exactly 4 bytes compared; Done after the 4th valid byte.
- RST pulse during CHECK. Required: immediate IDLE, all outputs at reset values, no Done. A subsequent Start with n=2 sends 8 bytes.
- RxFlag dropped after 3 checked bytes. Required: Done, Pass=0, TimeoutErr=0. Start pulses during Busy are ignored, with no state change.

Source files
------------

// File: rtl/prbs_bist_ctrl.sv
// prbs_bist_ctrl: self-test sequencer for the PRBS-15 pattern-detect/generate datapath.
// Sends the sync pattern n times, waits for Flag, then checks returned bytes against a reference LFSR.
module prbs_bist_ctrl #(
    parameter int          BusWidth = 8,
    parameter int          NumWidth = 4,
    parameter logic [31:0] Pattern  = 32'hAABBCCDD,
    parameter logic [14:0] Seed     = 15'h7FFF,
    parameter int          Timeout  = 32,
    parameter int          LenWidth = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Start,
    input  logic [NumWidth-1:0] n,
    input  logic [LenWidth-1:0] CheckLen,
    input  logic [LenWidth-1:0] ErrThresh,
    output logic [BusWidth-1:0] TxData,
    output logic                TxValid,
    input  logic                RxFlag,
    input  logic [BusWidth-1:0] RxData,
    input  logic                RxValid,
    output logic                Busy,
    output logic                Done,
    output logic                Pass,
    output logic                TimeoutErr,
    output logic [LenWidth-1:0] ErrCount
);

    localparam int SendW = NumWidth + 2;
    localparam int WaitW = $clog2(Timeout) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_FLAG,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [SendW-1:0]    r_send_tot;
    logic [SendW-1:0]    r_send_cnt;
    logic [BusWidth-1:0] r_tx_data;
    logic                r_tx_vld;
    logic [WaitW-1:0]    r_wait_cnt;
    logic [LenWidth-1:0] r_len;
    logic [LenWidth-1:0] r_thresh;
    logic [LenWidth-1:0] r_byte_cnt;
    logic [14:0]         r_lfsr;
    logic [LenWidth-1:0] r_err;
    logic                r_pass;
    logic                r_tmo;

    logic                w_start_acc;
    logic                w_send_last;
    logic                w_wait_tmo;
    logic                w_chk_empty;
    logic                w_chk_drop;
    logic                w_chk_acc;
    logic                w_chk_last;
    logic [NumWidth-1:0] w_n_eff;
    logic [14:0]         w_lfsr_nxt;
    logic [BusWidth-1:0] w_ref_byte;
    logic [LenWidth-1:0] w_err_nxt;

    function automatic logic [BusWidth-1:0] f_pat_byte(input logic [1:0] idx);
        logic [BusWidth-1:0] b;
        case (idx)
            2'd0:    b = Pattern[31:24];
            2'd1:    b = Pattern[23:16];
            2'd2:    b = Pattern[15:8];
            default: b = Pattern[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [14:0] f_lfsr_adv8(input logic [14:0] s);
        logic [14:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[13:0], t[14] ^ t[13]};
        end
        return t;
    endfunction

    function automatic logic [LenWidth-1:0] f_popcount(input logic [BusWidth-1:0] v);
        logic [LenWidth-1:0] c;
        c = '0;
        for (int i = 0; i < BusWidth; i++) begin
            c = c + LenWidth'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [LenWidth-1:0] f_sat_add(input logic [LenWidth-1:0] a,
                                                      input logic [LenWidth-1:0] b);
        logic [LenWidth:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LenWidth] ? '1 : s[LenWidth-1:0];
    endfunction

    assign w_n_eff    = (n == '0) ? NumWidth'(1) : n;
    assign w_lfsr_nxt = f_lfsr_adv8(r_lfsr);
    // The eight feedback bits land in the low byte of the advanced state, first bit at the MSB.
    assign w_ref_byte = w_lfsr_nxt[7:0];
    assign w_err_nxt  = f_sat_add(r_err, f_popcount(RxData ^ w_ref_byte));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_send_last = 1'b0;
        w_wait_tmo  = 1'b0;
        w_chk_empty = 1'b0;
        w_chk_drop  = 1'b0;
        w_chk_acc   = 1'b0;
        w_chk_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (r_send_cnt == r_send_tot - SendW'(1)) begin
                    w_send_last = 1'b1;
                    w_state_nxt = S_WAIT_FLAG;
                end
            end
            S_WAIT_FLAG: begin
                if (RxFlag) begin
                    w_state_nxt = S_CHECK;
                end else if (r_wait_cnt == WaitW'(Timeout - 1)) begin
                    w_wait_tmo  = 1'b1;
                    w_state_nxt = S_FINISH;
                end
            end
            S_CHECK: begin
                if (r_len == '0) begin
                    w_chk_empty = 1'b1;
                    w_state_nxt = S_FINISH;
                end else if (!RxFlag) begin
                    w_chk_drop  = 1'b1;
                    w_state_nxt = S_FINISH;
                end else if (RxValid) begin
                    w_chk_acc = 1'b1;
                    if (r_byte_cnt == r_len - LenWidth'(1)) begin
                        w_chk_last  = 1'b1;
                        w_state_nxt = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transmit side: byte sequencer for the repeated sync pattern.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_send_tot <= '0;
            r_send_cnt <= '0;
            r_tx_data  <= '0;
            r_tx_vld   <= 1'b0;
        end else if (w_start_acc) begin
            r_send_tot <= {w_n_eff, 2'b00};
            r_send_cnt <= '0;
            r_tx_data  <= f_pat_byte(2'd0);
            r_tx_vld   <= 1'b1;
        end else if (r_state == S_SEND) begin
            if (w_send_last) begin
                r_tx_data <= '0;
                r_tx_vld  <= 1'b0;
            end else begin
                r_send_cnt <= r_send_cnt + SendW'(1);
                r_tx_data  <= f_pat_byte(r_send_cnt[1:0] + 2'd1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wait_cnt <= '0;
        end else if (w_start_acc || (r_state == S_WAIT_FLAG && (RxFlag || w_wait_tmo))) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT_FLAG) begin
            r_wait_cnt <= r_wait_cnt + WaitW'(1);
        end
    end

    // Receive side: reference comparison and test result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_len      <= '0;
            r_thresh   <= '0;
            r_byte_cnt <= '0;
            r_lfsr     <= Seed;
            r_err      <= '0;
            r_pass     <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_len      <= CheckLen;
                r_thresh   <= ErrThresh;
                r_byte_cnt <= '0;
                r_lfsr     <= Seed;
                r_err      <= '0;
                r_pass     <= 1'b0;
                r_tmo      <= 1'b0;
            end
            if (w_wait_tmo) begin
                r_tmo  <= 1'b1;
                r_pass <= 1'b0;
            end
            if (w_chk_empty) begin
                r_pass <= 1'b1;
            end
            if (w_chk_drop) begin
                r_pass <= 1'b0;
                r_tmo  <= 1'b0;
            end
            if (w_chk_acc) begin
                r_err      <= w_err_nxt;
                r_lfsr     <= w_lfsr_nxt;
                r_byte_cnt <= r_byte_cnt + LenWidth'(1);
            end
            if (w_chk_last) begin
                r_pass <= (w_err_nxt <= r_thresh);
            end
        end
    end

    assign TxData     = r_tx_data;
    assign TxValid    = r_tx_vld;
    assign Busy       = (r_state != S_IDLE);
    assign Done       = (r_state == S_FINISH);
    assign Pass       = r_pass;
    assign TimeoutErr = r_tmo;
    assign ErrCount   = r_err;

endmodule

// File: tb/tb_prbs_bist_ctrl.sv
// Testbench for prbs_bist_ctrl: directed scenarios checked cycle by cycle against a
// trace model built from the sequencer's timing rules and a bit-sequence PRBS reference.
module tb_prbs_bist_ctrl;

    localparam int MAXC = 64;
    localparam int TMO  = 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  n = '0;
    logic [15:0] CheckLen = '0;
    logic [15:0] ErrThresh = '0;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        RxFlag = 1'b0;
    logic [7:0]  RxData = '0;
    logic        RxValid = 1'b0;
    logic        Busy;
    logic        Done;
    logic        Pass;
    logic        TimeoutErr;
    logic [15:0] ErrCount;

    int checks = 0;
    int failures = 0;

    prbs_bist_ctrl #(
        .BusWidth (8),
        .NumWidth (4),
        .Pattern  (32'hAABBCCDD),
        .Seed     (15'h7FFF),
        .Timeout  (TMO),
        .LenWidth (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .n          (n),
        .CheckLen   (CheckLen),
        .ErrThresh  (ErrThresh),
        .TxData     (TxData),
        .TxValid    (TxValid),
        .RxFlag     (RxFlag),
        .RxData     (RxData),
        .RxValid    (RxValid),
        .Busy       (Busy),
        .Done       (Done),
        .Pass       (Pass),
        .TimeoutErr (TimeoutErr),
        .ErrCount   (ErrCount)
    );

    initial forever #5 CLK = ~CLK;

    // PRBS reference as a plain bit sequence: y[k] = y[k-15] ^ y[k-14], seed bits first (MSB oldest).
    int prbs_bit [15 + 8*MAXC];
    logic [14:0] seed_v;
    logic [31:0] pat_v;

    int exp_txv[MAXC], exp_txd[MAXC], exp_busy[MAXC], exp_done[MAXC];
    int exp_pass[MAXC], exp_tmo[MAXC], exp_err[MAXC];
    int st_start[MAXC], st_flag[MAXC], st_vld[MAXC], st_data[MAXC];
    int prev_pass = 0, prev_tmo = 0, prev_err = 0;
    int cur_k = 0;
    bit cmp_en = 1'b0;
    int done_cycle, txv_cnt, last_k;

    function automatic int ref_byte(input int j);
        int b;
        b = 0;
        for (int i = 0; i < 8; i++) b = (b << 1) | prbs_bit[15 + 8*j + i];
        return b;
    endfunction

    function automatic int pat_byte(input int idx);
        return int'((pat_v >> (8 * (3 - idx))) & 32'hFF);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            st_start[c] = 0; st_flag[c] = 0; st_vld[c] = 0; st_data[c] = 0;
        end
    endtask

    task automatic fill_vld(input int from, input int step, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            st_vld[from + i*step]  = 1;
            st_data[from + i*step] = ref_byte(i);
        end
    endtask

    // Cycle k = the interval after the k-th clock edge; Start is driven in cycle 0.
    task automatic build_expect(input int nn, input int len, input int thr);
        int t, w0, c0, f, c, j, err, pass_f, tmo_f, e;
        int acc [MAXC];
        t  = 4 * ((nn == 0) ? 1 : nn);
        w0 = t + 1;
        c0 = -1;
        for (int cc = w0; cc < w0 + TMO; cc++) begin
            if (c0 < 0 && st_flag[cc] != 0) c0 = cc + 1;
        end
        for (int i = 0; i < MAXC; i++) acc[i] = -1;
        err = 0; j = 0; pass_f = 0; tmo_f = 0; f = 0;
        if (c0 < 0) begin
            f = w0 + TMO; tmo_f = 1;
        end else begin
            c = c0;
            while (f == 0) begin
                if (c >= MAXC - 3) begin
                    $display("FAIL model_range: got cycle %0d, required below %0d", c, MAXC - 3);
                    failures++;
                    f = MAXC - 3;
                end else if (len == 0) begin
                    f = c + 1; pass_f = 1;
                end else if (st_flag[c] == 0) begin
                    f = c + 1; pass_f = 0;
                end else if (st_vld[c] != 0) begin
                    err = err + $countones(st_data[c] ^ ref_byte(j));
                    if (err > 65535) err = 65535;
                    acc[c] = err;
                    j++;
                    if (j == len) begin
                        f = c + 1; pass_f = (err <= thr) ? 1 : 0;
                    end
                end
                c++;
            end
        end
        last_k = f + 2;
        e = 0;
        for (int k = 0; k <= last_k; k++) begin
            exp_txv[k]  = (k >= 1 && k <= t) ? 1 : 0;
            exp_txd[k]  = (exp_txv[k] != 0) ? pat_byte((k - 1) % 4) : 0;
            exp_busy[k] = (k >= 1 && k <= f) ? 1 : 0;
            exp_done[k] = (k == f) ? 1 : 0;
            exp_pass[k] = (k == 0) ? prev_pass : ((k < f) ? 0 : pass_f);
            exp_tmo[k]  = (k == 0) ? prev_tmo : ((k < f) ? 0 : tmo_f);
            exp_err[k]  = (k == 0) ? prev_err : e;
            if (acc[k] >= 0) e = acc[k];
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk($sformatf("TxValid@%0d", cur_k), int'(TxValid), exp_txv[cur_k]);
            chk($sformatf("TxData@%0d", cur_k), int'(TxData), exp_txd[cur_k]);
            chk($sformatf("Busy@%0d", cur_k), int'(Busy), exp_busy[cur_k]);
            chk($sformatf("Done@%0d", cur_k), int'(Done), exp_done[cur_k]);
            chk($sformatf("Pass@%0d", cur_k), int'(Pass), exp_pass[cur_k]);
            chk($sformatf("TimeoutErr@%0d", cur_k), int'(TimeoutErr), exp_tmo[cur_k]);
            chk($sformatf("ErrCount@%0d", cur_k), int'(ErrCount), exp_err[cur_k]);
        end
    end

    task automatic run_test(input int nn, input int len, input int thr, input int abort_k);
        build_expect(nn, len, thr);
        done_cycle = -1;
        txv_cnt = 0;
        for (int k = 0; k <= last_k; k++) begin
            Start     = (st_start[k] != 0);
            n         = (k == 0) ? 4'(nn) : 4'hF;
            CheckLen  = (k == 0) ? 16'(len) : 16'h0000;
            ErrThresh = (k == 0) ? 16'(thr) : 16'hFFFF;
            RxFlag    = (st_flag[k] != 0);
            RxValid   = (st_vld[k] != 0);
            RxData    = 8'(st_data[k]);
            cur_k  = k;
            cmp_en = 1'b1;
            @(negedge CLK);
            #1;
            if (Done) done_cycle = k;
            if (TxValid) txv_cnt++;
            if (k == abort_k) break;
            @(posedge CLK);
            #1;
        end
        cmp_en = 1'b0;
        Start = 1'b0; RxFlag = 1'b0; RxValid = 1'b0; RxData = '0;
        if (abort_k < 0) begin
            prev_pass = exp_pass[last_k];
            prev_tmo  = exp_tmo[last_k];
            prev_err  = exp_err[last_k];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seed_v = 15'h7FFF;
        pat_v  = 32'hAABBCCDD;
        for (int i = 0; i < 15; i++) prbs_bit[i] = int'(seed_v[14 - i]);
        for (int k = 15; k < 15 + 8*MAXC; k++) prbs_bit[k] = prbs_bit[k-15] ^ prbs_bit[k-14];
        chk("model_ref_byte0", ref_byte(0), 8'h00);
        chk("model_ref_byte1", ref_byte(1), 8'h02);
        chk("model_ref_byte3", ref_byte(3), 8'h0C);

        // Reset with a coincident Start: reset wins.
        Start = 1'b1; n = 4'd1; CheckLen = 16'd4;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_Busy", int'(Busy), 0);
        chk("rst_TxValid", int'(TxValid), 0);
        chk("rst_TxData", int'(TxData), 0);
        chk("rst_Done", int'(Done), 0);
        chk("rst_Pass", int'(Pass), 0);
        chk("rst_TimeoutErr", int'(TimeoutErr), 0);
        chk("rst_ErrCount", int'(ErrCount), 0);
        Start = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_Busy", int'(Busy), 0);

        // Clean loopback, n=4, 16 bytes.
        clear_stim(); st_start[0] = 1;
        for (int c = 17; c < MAXC; c++) st_flag[c] = 1;
        fill_vld(18, 1, 16);
        run_test(4, 16, 0, -1);
        chk("t1_done_cycle", done_cycle, 34);
        chk("t1_tx_count", txv_cnt, 16);
        chk("t1_Pass", int'(Pass), 1);
        chk("t1_ErrCount", int'(ErrCount), 0);

        // Single bit error in byte 1, threshold 0 then 1.
        st_data[19] = 8'h03;
        run_test(4, 16, 0, -1);
        chk("t2_ErrCount", int'(ErrCount), 1);
        chk("t2_Pass", int'(Pass), 0);
        run_test(4, 16, 1, -1);
        chk("t3_Pass", int'(Pass), 1);

        // n=0 sends one pattern; RxValid toggles, garbage on idle cycles.
        clear_stim(); st_start[0] = 1;
        for (int c = 5; c < MAXC; c++) st_flag[c] = 1;
        fill_vld(6, 2, 6);
        st_data[7] = 8'hFF; st_data[9] = 8'hFF; st_data[11] = 8'hFF;
        run_test(0, 4, 0, -1);
        chk("t5_tx_count", txv_cnt, 4);
        chk("t5_done_cycle", done_cycle, 13);
        chk("t5_Pass", int'(Pass), 1);

        // Reset pulse during CHECK with errors already counted.
        clear_stim(); st_start[0] = 1;
        for (int c = 5; c < MAXC; c++) st_flag[c] = 1;
        fill_vld(6, 1, 10);
        for (int c = 6; c < 16; c++) st_data[c] = st_data[c] ^ 8'hFF;
        run_test(1, 10, 0, 9);
        RST = 1'b1;
        #1;
        chk("abort_Busy", int'(Busy), 0);
        chk("abort_TxValid", int'(TxValid), 0);
        chk("abort_TxData", int'(TxData), 0);
        chk("abort_Pass", int'(Pass), 0);
        chk("abort_TimeoutErr", int'(TimeoutErr), 0);
        chk("abort_ErrCount", int'(ErrCount), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("abort_Done_%0d", i), int'(Done), 0);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        prev_pass = 0; prev_tmo = 0; prev_err = 0;
        clear_stim(); st_start[0] = 1;
        for (int c = 9; c < MAXC; c++) st_flag[c] = 1;
        fill_vld(10, 1, 2);
        run_test(2, 2, 0, -1);
        chk("t6_tx_count", txv_cnt, 8);
        chk("t6_done_cycle", done_cycle, 12);

        // RxFlag never asserted.
        clear_stim(); st_start[0] = 1;
        run_test(1, 4, 0, -1);
        chk("t4_done_cycle", done_cycle, 37);
        chk("t4_TimeoutErr", int'(TimeoutErr), 1);
        chk("t4_Pass", int'(Pass), 0);
        chk("t4_ErrCount", int'(ErrCount), 0);

        // RxFlag drops after 3 checked bytes; extra Start pulses while busy.
        clear_stim();
        st_start[0] = 1; st_start[2] = 1; st_start[6] = 1; st_start[10] = 1;
        for (int c = 5; c <= 8; c++) st_flag[c] = 1;
        fill_vld(6, 1, 8);
        run_test(1, 8, 0, -1);
        chk("t7_done_cycle", done_cycle, 10);
        chk("t7_Pass", int'(Pass), 0);
        chk("t7_TimeoutErr", int'(TimeoutErr), 0);
        chk("t7_Busy_after", int'(Busy), 0);

        // CheckLen=0 passes immediately.
        clear_stim(); st_start[0] = 1;
        for (int c = 5; c < MAXC; c++) st_flag[c] = 1;
        run_test(1, 0, 0, -1);
        chk("t8_done_cycle", done_cycle, 7);
        chk("t8_Pass", int'(Pass), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
